// File: rtl/arbitro_rx_uart_pkg.sv
// Shared types and register offsets for the UART receive arbiter.
// Optional per-channel statistics are enabled by defining ARBITRO_RX_STATS_EN.
package arbitro_rx_uart_pkg;

    typedef struct packed {
        logic [1:0] tag;
        logic [7:0] dato;
    } entrada_fifo_t;

    localparam logic [1:0] OFS_STATUS  = 2'd0;
    localparam logic [1:0] OFS_DATA    = 2'd1;
    localparam logic [1:0] OFS_CONTROL = 2'd2;
    localparam logic [1:0] OFS_STATS   = 2'd3;

    localparam logic [1:0] TAG_A = 2'd0;
    localparam logic [1:0] TAG_B = 2'd1;
    localparam logic [1:0] TAG_C = 2'd2;

    localparam int CTRL_FLUSH_BIT = 3;

endpackage

// File: rtl/fifo_sincrona_etiquetada.sv
// Synchronous FIFO of tagged bytes with flush; head is presented combinationally.
module fifo_sincrona_etiquetada
    import arbitro_rx_uart_pkg::*;
#(
    parameter  int PROFUNDIDAD = 16,
    localparam int AW          = $clog2(PROFUNDIDAD)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          push_i,
    input  entrada_fifo_t dato_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o,
    output entrada_fifo_t cabeza_o
);

    entrada_fifo_t mem [PROFUNDIDAD];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign full_o   = (count == (AW+1)'(PROFUNDIDAD));
    assign empty_o  = (count == '0);
    assign count_o  = count;
    assign cabeza_o = mem[rd_ptr];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem[wr_ptr] <= dato_i;
    end

endmodule

// File: rtl/arbitro_rx_uart.sv
// Round-robin merge of three UART receive streams into one tagged FIFO behind a CPU register window.
// Define ARBITRO_RX_STATS_EN to add saturating per-channel accepted-byte counters (STATS register).
module arbitro_rx_uart
    import arbitro_rx_uart_pkg::*;
#(
    parameter  int N_CANALES   = 3,
    parameter  int PROFUNDIDAD = 16,
    localparam int AW          = $clog2(PROFUNDIDAD)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [N_CANALES-1:0]      rx_valid_i,
    input  logic [N_CANALES-1:0][7:0] rx_dato_i,
    output logic [N_CANALES-1:0]      rx_ready_o,
    input  logic                      we_i,
    input  logic                      re_i,
    input  logic [1:0]                addr_i,
    input  logic [31:0]               dato_i,
    output logic [31:0]               salida_o
);

    logic [N_CANALES-1:0] mask, elegible;
    logic [1:0]           rr_ptr, idx_conc;
    logic                 concedido, flush, pop, full, empty;
    logic [AW:0]          count;
    entrada_fifo_t        entrada, cabeza;
    logic [31:0]          stats;
    logic                 unused_dato;
    int                   ch;

    assign unused_dato = ^dato_i[31:CTRL_FLUSH_BIT+1];

    assign flush    = we_i & (addr_i == OFS_CONTROL) & dato_i[CTRL_FLUSH_BIT];
    assign pop      = re_i & (addr_i == OFS_DATA) & ~flush;
    assign elegible = rx_valid_i & mask;

    // First eligible channel starting at the RR pointer, wrapping back to A.
    always_comb begin
        rx_ready_o = '0;
        concedido  = 1'b0;
        idx_conc   = '0;
        ch         = 0;
        if (!full && !flush) begin
            for (int k = 0; k < N_CANALES; k++) begin
                ch = int'(rr_ptr) + k;
                if (ch >= N_CANALES) ch = ch - N_CANALES;
                if (!concedido && elegible[ch]) begin
                    concedido = 1'b1;
                    idx_conc  = 2'(ch);
                end
            end
        end
        if (concedido) rx_ready_o[idx_conc] = 1'b1;
    end

    assign entrada.tag  = idx_conc;
    assign entrada.dato = rx_dato_i[idx_conc];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_ptr <= '0;
            mask   <= '1;
        end else begin
            if (concedido)
                rr_ptr <= (idx_conc == 2'(N_CANALES-1)) ? 2'd0 : idx_conc + 2'd1;
            if (we_i && addr_i == OFS_CONTROL)
                mask <= dato_i[N_CANALES-1:0];
        end
    end

    fifo_sincrona_etiquetada #(.PROFUNDIDAD(PROFUNDIDAD)) u_fifo (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .push_i   (concedido),
        .dato_i   (entrada),
        .pop_i    (pop),
        .flush_i  (flush),
        .full_o   (full),
        .empty_o  (empty),
        .count_o  (count),
        .cabeza_o (cabeza)
    );

`ifdef ARBITRO_RX_STATS_EN
    logic [N_CANALES-1:0][7:0] cnt;

    always_ff @(posedge clk_i) begin
        if (reset_i || flush)
            cnt <= '0;
        else if (concedido && cnt[idx_conc] != 8'hFF)
            cnt[idx_conc] <= cnt[idx_conc] + 8'd1;
    end

    assign stats = 32'(cnt);
`else
    assign stats = 32'h0;
`endif

    always_comb begin
        salida_o = '0;
        case (addr_i)
            OFS_STATUS: begin
                salida_o[AW:0] = count;
                salida_o[8]    = empty;
                salida_o[9]    = full;
            end
            OFS_DATA:    salida_o = empty ? 32'h8000_0000 : {22'b0, cabeza.tag, cabeza.dato};
            OFS_CONTROL: salida_o[N_CANALES-1:0] = mask;
            OFS_STATS:   salida_o = stats;
            default:     salida_o = '0;
        endcase
    end

endmodule
